// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the HDMI rPLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_SER   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser; output lags input by two clk edges.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: pulses pll_reset, waits for stable lock, then releases ser_rst and pix_rst.
// Define PLL_LOSS_CNT_EN to add the loss_cnt output counting lock losses after release.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGE_GAP    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic               ser_rst,
  output logic               pix_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);

  localparam int MAX_P = max2(max2(RST_CYCLES, LOCK_TIMEOUT), max2(LOCK_STABLE, STAGE_GAP));
  localparam int CNT_W = $clog2(MAX_P) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Each state runs until cnt reaches zero, so loads are one less than the dwell time.
  // The cycle where lock_s first rises counts toward LOCK_STABLE, hence the extra -1.
  localparam cnt_t RST_LOAD  = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t TMO_LOAD  = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STB_LOAD  = cnt_t'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
  localparam cnt_t GAP_LOAD  = cnt_t'(STAGE_GAP - 1);

  state_t state, state_nxt;
  cnt_t   cnt, cnt_nxt;
  logic   lock_s;
  logic   retry_inc;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (lock_s)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - cnt_t'(1);
    retry_inc = 1'b0;

    if (restart) begin
      state_nxt = S_RESET;
      cnt_nxt   = RST_LOAD;
    end else begin
      unique case (state)
        S_RESET: begin
          if (cnt == '0) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = TMO_LOAD;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            // A lock seen on the timeout cycle wins over the retry.
            if (LOCK_STABLE == 1) begin
              state_nxt = S_REL_SER;
              cnt_nxt   = GAP_LOAD;
            end else begin
              state_nxt = S_STABLE;
              cnt_nxt   = STB_LOAD;
            end
          end else if (cnt == '0) begin
            state_nxt = S_RESET;
            cnt_nxt   = RST_LOAD;
            retry_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = TMO_LOAD;
          end else if (cnt == '0) begin
            state_nxt = S_REL_SER;
            cnt_nxt   = GAP_LOAD;
          end
        end
        S_REL_SER: begin
          if (!lock_s) begin
            state_nxt = S_RESET;
            cnt_nxt   = RST_LOAD;
          end else if (cnt == '0) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          cnt_nxt = cnt;
          if (!lock_s) begin
            state_nxt = S_RESET;
            cnt_nxt   = RST_LOAD;
          end
        end
        default: begin
          state_nxt = S_RESET;
          cnt_nxt   = RST_LOAD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet change on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RESET;
      cnt       <= RST_LOAD;
      pll_reset <= 1'b1;
      ser_rst   <= 1'b1;
      pix_rst   <= 1'b1;
      ready     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_reset <= (state_nxt == S_RESET);
      ser_rst   <= !(state_nxt inside {S_REL_SER, S_RUN});
      pix_rst   <= (state_nxt != S_RUN);
      ready     <= (state_nxt == S_RUN);
      if (retry_inc && (retry_cnt != '1))
        retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic loss_ev;

  // Only a genuine lock drop after release counts; restart overrides it.
  always_comb begin
    loss_ev = !restart && !lock_s && (state inside {S_REL_SER, S_RUN});
  end

  always_ff @(posedge clk) begin
    if (reset)
      loss_cnt <= '0;
    else if (loss_ev && (loss_cnt != '1))
      loss_cnt <= loss_cnt + LOSS_W'(1);
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a timestamp-based model predicts each cycle's outputs.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TMO   = 50;
  localparam int STB   = 8;
  localparam int GAP   = 3;

  logic       clk = 1'b0;
  logic       reset, lock, restart;
  logic       pll_reset, ser_rst, pix_rst, ready;
  logic [7:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TMO),
    .LOCK_STABLE  (STB),
    .STAGE_GAP    (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lock      (lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .ser_rst   (ser_rst),
    .pix_rst   (pix_rst),
    .ready     (ready),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pll_reset;
    logic        ser_rst;
    logic        pix_rst;
    logic        ready;
    logic [7:0]  retry;
    logic [15:0] loss;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   vectors     = 0;
  int   miscompares = 0;

  // Model: the sequence is described by when waiting starts and when the current lock run began.
  int   cyc        = 0;
  int   wait_start = 0;
  int   lock_since = -1;
  int   retries    = 0;
  int   losses     = 0;
  logic s1 = 1'b0, s2 = 1'b0;

  task automatic model_edge();
    logic ls;
    exp_t e;
    int   m;
    ls = s2;
    if (reset) begin
      retries    = 0;
      losses     = 0;
      wait_start = cyc + 1 + RST_C;
      lock_since = -1;
    end else if (restart) begin
      wait_start = cyc + 1 + RST_C;
      lock_since = -1;
    end else if (cyc < wait_start) begin
      // PLL still held in reset: lock is ignored.
    end else if (lock_since < 0) begin
      if (ls)
        lock_since = cyc;
      else if (cyc - wait_start == TMO - 1) begin
        if (retries < 255) retries++;
        wait_start = cyc + 1 + RST_C;
      end
    end else if (!ls) begin
      if (cyc >= lock_since + STB) begin
        if (losses < 65535) losses++;
        wait_start = cyc + 1 + RST_C;
      end else begin
        wait_start = cyc + 1;
      end
      lock_since = -1;
    end

    if (reset) begin
      s1 = 1'b0;
      s2 = 1'b0;
    end else begin
      s2 = s1;
      s1 = lock;
    end

    cyc++;
    m = cyc;
    e.pll_reset = (m < wait_start);
    e.ser_rst   = !(lock_since >= 0 && m >= lock_since + STB);
    e.pix_rst   = !(lock_since >= 0 && m >= lock_since + STB + GAP);
    e.ready     = !e.pix_rst;
    e.retry     = 8'(retries);
`ifdef PLL_LOSS_CNT_EN
    e.loss      = 16'(losses);
`else
    e.loss      = 16'h0;
`endif
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic rs, input logic lk);
    reset   = r;
    restart = rs;
    lock    = lk;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n, input logic r, input logic rs, input logic lk);
    for (int i = 0; i < n; i++) step(r, rs, lk);
  endtask

  // Monitor: pops one prediction per cycle and compares on the falling edge.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.pll_reset = pll_reset;
        got.ser_rst   = ser_rst;
        got.pix_rst   = pix_rst;
        got.ready     = ready;
        got.retry     = retry_cnt;
`ifdef PLL_LOSS_CNT_EN
        got.loss      = loss_cnt;
`else
        got.loss      = 16'h0;
`endif
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got pll_reset=%b ser_rst=%b pix_rst=%b ready=%b retry=%0d loss=%0d, want %b %b %b %b retry=%0d loss=%0d",
                   $time, got.pll_reset, got.ser_rst, got.pix_rst, got.ready, got.retry, got.loss,
                   e.pll_reset, e.ser_rst, e.pix_rst, e.ready, e.retry, e.loss);
        end
      end
    end
  end

  initial begin
    logic lk;
    int   guard;

    // Scenario 1: clean lock-up.
    run(3, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b0, 1'b0);
    run(25, 1'b0, 1'b0, 1'b1);

    // Scenario 4: lock drop while running, then re-lock.
    step(1'b0, 1'b0, 1'b0);
    run(30, 1'b0, 1'b0, 1'b1);

    // Scenario 5: restart coinciding with a lock drop.
    step(1'b0, 1'b1, 1'b0);
    run(30, 1'b0, 1'b0, 1'b1);

    // Scenario 3: two-cycle glitch while lock is being qualified.
    step(1'b1, 1'b0, 1'b1);
    run(7, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);
    run(20, 1'b0, 1'b0, 1'b1);

    // Scenario 6: reset while the serializer is released but pixel domain is not.
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    do begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end while (!(last_exp.ser_rst == 1'b0 && last_exp.pix_rst == 1'b1) && guard < 60);
    if (guard >= 60) begin
      miscompares++;
      $display("FAIL rel_ser_reach: got no serializer-only release within 60 cycles, want one");
    end
    step(1'b1, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0, 1'b1);

    // Scenario 2: lock never arrives; retries count up and saturate.
    step(1'b1, 1'b0, 1'b0);
    run(300 * (RST_C + TMO) + 200, 1'b0, 1'b0, 1'b0);
    run(30, 1'b0, 1'b0, 1'b1);

    // Randomised lock activity with occasional restart and reset.
    step(1'b1, 1'b0, 1'b0);
    lk = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) lk = ~lk;
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) == 0), lk);
    end
    run(4, 1'b0, 1'b0, lk);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked predictions, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
